bus_packer: RTL and testbench

Width up-converter: accepts a stream of `BUS_WIDTH`-bit beats and packs every `DATA_WIDTH/BUS_WIDTH` beats into one `DATA_WIDTH`-bit word. Packed words are buffered in an internal FIFO of `FIFO_DEPTH` entries. Sits on the receive side of the bus, opposite the word-to-beat unpacker. Both sides use valid/ready handshakes; `in_last` flushes a partial word.

---
 rtl/bus_packer_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/bus_packer.sv | 86 ++++++++
 tb/tb_bus_packer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_packer_pkg.sv
// Shared configuration helpers for the bus_packer width up-converter.
// Derived widths and legality checks for the beat/word/FIFO geometry.
package bus_packer_pkg;

  function automatic int unsigned calc_ratio(input int unsigned data_w, input int unsigned bus_w);
    return data_w / bus_w;
  endfunction

  // Beat counter needs at least one bit even when every beat is a word.
  function automatic int unsigned calc_cnt_w(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic int unsigned calc_level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit cfg_ok(input int unsigned data_w, input int unsigned bus_w,
                                input int unsigned depth);
    return (bus_w != 0) && (data_w % bus_w == 0) && is_pow2(data_w / bus_w) &&
           is_pow2(depth) && (depth >= 2);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered write and separate occupancy count.
// Head entry is visible on rdata one cycle after it is pushed.
module sync_fifo
  import bus_packer_pkg::*;
#(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 512
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic                             pop,
  input  logic [WIDTH-1:0]                 wdata,
  output logic [WIDTH-1:0]                 rdata,
  output logic                             full,
  output logic                             empty,
  output logic [calc_level_w(DEPTH)-1:0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = calc_level_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign full  = (r_count == LW'(DEPTH));
  assign empty = (r_count == '0);
  assign level = r_count;
  assign rdata = r_mem[r_rptr];

endmodule

// File: rtl/bus_packer.sv
// Packs BUS_WIDTH-bit beats into DATA_WIDTH-bit words, lane 0 first, and buffers
// them in a show-ahead FIFO; in_last closes a partial word with zero-filled lanes.
module bus_packer
  import bus_packer_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 512
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [BUS_WIDTH-1:0]                  in_data,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic                                  out_last,
  output logic [calc_level_w(FIFO_DEPTH)-1:0]   out_level
);

  localparam int unsigned RATIO = calc_ratio(DATA_WIDTH, BUS_WIDTH);
  localparam int unsigned CNT_W = calc_cnt_w(RATIO);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  if (!cfg_ok(DATA_WIDTH, BUS_WIDTH, FIFO_DEPTH)) begin : g_cfg_check
    $error("bus_packer: illegal BUS_WIDTH/DATA_WIDTH/FIFO_DEPTH combination");
  end

  logic [CNT_W-1:0]      r_beat_cnt;
  logic [DATA_WIDTH-1:0] r_partial;
  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH:0]   w_rdata;
  logic                  w_accept;
  logic                  w_close;
  logic                  w_full;
  logic                  w_empty;

  assign w_accept = in_valid & in_ready;
  assign w_close  = w_accept & ((r_beat_cnt == LAST_BEAT) | in_last);

  // Current beat overlays its lane on the partially assembled word.
  always_comb begin
    w_word = r_partial;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (r_beat_cnt == CNT_W'(k)) w_word[k*BUS_WIDTH +: BUS_WIDTH] = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_partial  <= '0;
    end else if (w_accept) begin
      if (w_close) begin
        r_beat_cnt <= '0;
        r_partial  <= '0;
      end else begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        r_partial  <= w_word;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_close),
    .pop   (out_ready),
    .wdata ({in_last, w_word}),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .level (out_level)
  );

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_data  = w_empty ? '0 : w_rdata[DATA_WIDTH-1:0];
  assign out_last  = ~w_empty & w_rdata[DATA_WIDTH];

endmodule

// File: tb/tb_bus_packer.sv
// Self-checking bench for bus_packer: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_bus_packer;

  localparam int unsigned BW    = 32;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RATIO = DW / BW;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [LW-1:0] out_level;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } word_t;

  word_t         mq[$];  // words expected in the FIFO, head first
  logic [BW-1:0] bq[$];  // beats of the word being assembled

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          l;
    bit          ordy;
    bit          ov;
    logic [63:0] od;
    bit          ol;
    int          lvl;
    bit          ir;
  } vec_t;

  bus_packer #(
    .BUS_WIDTH  (BW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_level (out_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    word_t h;
    h = '0;
    if (mq.size() > 0) h = mq[0];
    chk("out_valid", out_valid, mq.size() > 0);
    chk("out_data", out_data, h.data);
    chk("out_last", out_last, h.last);
    chk("out_level", out_level, mq.size());
    chk("in_ready", in_ready, mq.size() < DEPTH);
  endtask

  // One clock: drive, compare against the model, advance model and DUT.
  task automatic cycle(input bit v, input logic [BW-1:0] d, input bit l, input bit ordy,
                       output bit acc);
    bit            pop;
    logic [DW-1:0] w;
    word_t         nw;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    #1;
    check_model();
    acc = v && (mq.size() < DEPTH);
    pop = ordy && (mq.size() > 0);
    if (pop) void'(mq.pop_front());
    if (acc) begin
      bq.push_back(d);
      if (bq.size() == RATIO || l) begin
        w = '0;
        foreach (bq[k]) w[k*BW +: BW] = bq[k];
        nw.last = l;
        nw.data = w;
        mq.push_back(nw);
        bq.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    bq.delete();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_level", out_level, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit a;
    for (int c = 0; c < 3 * DEPTH && mq.size() > 0; c++) cycle(1'b0, '0, 1'b0, 1'b1, a);
    chk("drain_out_valid", out_valid, 1'b0);
    chk("drain_out_level", out_level, 0);
  endtask

  initial begin
    vec_t tbl[6];
    bit   a;
    int   nacc;
    bit   pend;
    logic [31:0] pd;
    bit   pl;

    tbl[0] = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 0, 1'b1};
    tbl[1] = '{1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 0, 1'b1};
    tbl[2] = '{1'b1, 32'hAAAA5555, 1'b1, 1'b0, 1'b1, 64'h2222222211111111, 1'b0, 1, 1'b1};
    tbl[3] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 64'h2222222211111111, 1'b0, 2, 1'b1};
    tbl[4] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 64'h00000000AAAA5555, 1'b1, 1, 1'b1};
    tbl[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 0, 1'b1};

    // Directed vectors: full word, then partial flush.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      chk("tbl_out_valid", out_valid, tbl[i].ov);
      chk("tbl_out_data", out_data, tbl[i].od);
      chk("tbl_out_last", out_last, tbl[i].ol);
      chk("tbl_out_level", out_level, tbl[i].lvl);
      chk("tbl_in_ready", in_ready, tbl[i].ir);
      cycle(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy, a);
    end

    // Fill to full with out_ready low, hold beats 9-10, then drain.
    do_reset();
    nacc = 0;
    for (int c = 0; c < 16 && nacc < 8; c++) begin
      cycle(1'b1, 32'hF0000000 + nacc, 1'b0, 1'b0, a);
      if (a) nacc++;
    end
    chk("fill_accepted", nacc, 8);
    chk("fill_level", out_level, 4);
    chk("fill_in_ready", in_ready, 1'b0);
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 32'hF0000000 + nacc, 1'b0, 1'b0, a);
      chk("fill_held", a, 1'b0);
    end
    chk("fill_ready_before_pop", in_ready, 1'b0);
    cycle(1'b1, 32'hF0000000 + nacc, 1'b0, 1'b1, a);
    chk("fill_ready_after_pop", in_ready, 1'b1);
    for (int c = 0; c < 8 && nacc < 10; c++) begin
      cycle(1'b1, 32'hF0000000 + nacc, 1'b0, 1'b1, a);
      if (a) nacc++;
    end
    chk("fill_all_beats", nacc, 10);
    drain();

    // Level held at 2 by simultaneous push/pop; pointers wrap three times.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, a);
    chk("pp_level_init", out_level, 2);
    for (int n = 0; n < 6 * DEPTH; n++) begin
      cycle(1'b1, $urandom, 1'b0, n[0], a);
      chk("pp_accept", a, 1'b1);
      if (n[0]) chk("pp_level", out_level, 2);
    end
    drain();

    // Reset mid-word discards the stored lane.
    do_reset();
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, a);
    do_reset();
    cycle(1'b1, 32'h00000001, 1'b0, 1'b0, a);
    cycle(1'b1, 32'h00000002, 1'b0, 1'b0, a);
    chk("rstmid_valid", out_valid, 1'b1);
    chk("rstmid_data", out_data, 64'h0000000200000001);
    chk("rstmid_last", out_last, 1'b0);
    drain();

    // Random traffic on both sides; an offered beat is held until accepted.
    do_reset();
    nacc = 0;
    pend = 1'b0;
    pd   = '0;
    pl   = 1'b0;
    for (int c = 0; c < 60000 && nacc < 10000; c++) begin
      if (!pend) begin
        pend = ($urandom_range(9) < 7);
        pd   = $urandom;
        pl   = ($urandom_range(7) == 0);
      end
      cycle(pend, pd, pl, $urandom_range(9) < 6, a);
      if (a) begin
        nacc++;
        pend = 1'b0;
      end
    end
    chk("rand_beats", nacc, 10000);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
